// File: rtl/clk_reset_ce_gen.sv
// Reset sequencer and clock-enable source for the Z8 system.
// Syncs PLL lock and button, holds reset, then emits cpu_ce and tick_ms.
module clk_reset_ce_gen #(
    parameter int HOLD_CYCLES     = 1024,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int CE_DIV          = 4,
    parameter int TICK_DIV        = 48000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       btn_reset_n,
    output logic       sys_reset,
    output logic       cpu_ce,
    output logic       tick_ms,
    output logic [1:0] state
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int CW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CE_LAST   = CW'(CE_DIV - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2,
        ILLEGAL   = 2'd3
    } state_e;

    logic          lock_meta_q, lock_s_q;
    logic          btn_meta_q, btn_s_q;
    logic          btn_stable_q, btn_stable_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    state_e        state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [CW-1:0] ce_cnt_q, ce_cnt_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick_q, tick_d;
    logic          ok;
    logic          run;

    // Button idles high, so its synchronizer resets to the released level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            btn_meta_q  <= 1'b1;
            btn_s_q     <= 1'b1;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
            btn_meta_q  <= btn_reset_n;
            btn_s_q     <= btn_meta_q;
        end
    end

    always_comb begin
        btn_stable_d = btn_stable_q;
        db_cnt_d     = '0;
        if (btn_s_q != btn_stable_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_stable_d = btn_s_q;
            end else begin
                db_cnt_d = db_cnt_q + DW'(1);
            end
        end
    end

    assign ok = lock_s_q & btn_stable_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_stable_q <= 1'b1;
            db_cnt_q     <= '0;
            state_q      <= WAIT_LOCK;
            hold_cnt_q   <= '0;
            ce_cnt_q     <= '0;
            tick_cnt_q   <= '0;
            tick_q       <= 1'b0;
        end else begin
            btn_stable_q <= btn_stable_d;
            db_cnt_q     <= db_cnt_d;
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            ce_cnt_q     <= ce_cnt_d;
            tick_cnt_q   <= tick_cnt_d;
            tick_q       <= tick_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                if (ok) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                end
            end
            HOLD: begin
                if (!ok) begin
                    state_d    = WAIT_LOCK;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            RUN: begin
                if (!ok) begin
                    state_d    = WAIT_LOCK;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d    = WAIT_LOCK;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        run       = (state_q == RUN);
        sys_reset = ~run;
        cpu_ce    = run & (ce_cnt_q == CE_LAST);
        state     = state_q;
        tick_ms   = tick_q;
    end

    // CE phase restarts at 0 on every entry to RUN
    always_comb begin
        ce_cnt_d = '0;
        if (run && ce_cnt_q != CE_LAST) begin
            ce_cnt_d = ce_cnt_q + CW'(1);
        end
    end

    always_comb begin
        tick_d     = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick_d ? '0 : tick_cnt_q + TW'(1);
    end

endmodule
